// File: rtl/iecdrv_pkg.sv
// Shared types for the multi-drive ROM slot arbiter: tag format carried
// alongside each in-flight ROM read, plus cluster-wide limits.
package iecdrv_pkg;

    localparam int IECDRV_MAX_DRIVES = 8;
    localparam int IECDRV_MAX_LAT    = 4;

    typedef struct packed {
        logic       valid;
        logic [2:0] id;
        logic       sel;
    } rom_tag_t;

    localparam rom_tag_t ROM_TAG_IDLE = '{valid: 1'b0, id: 3'd0, sel: 1'b0};

    // Build a tag; an invalid tag carries zeroed fields so idle slots look identical
    function automatic rom_tag_t rom_tag_make(input logic valid, input logic [2:0] id,
                                              input logic sel);
        rom_tag_t t;
        t.valid = valid;
        t.id    = valid ? id : 3'd0;
        t.sel   = valid ? sel : 1'b0;
        return t;
    endfunction

endpackage

// File: rtl/iecdrv_rom_tagpipe.sv
// Latency-matched tag delay line: a tag pushed with an address emerges exactly
// when the ROM data for that address is ready to be sampled.
module iecdrv_rom_tagpipe
    import iecdrv_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  rom_tag_t tag_in,
    output rom_tag_t tag_out
);

    rom_tag_t pipe_r [LAT];

    // Shift tags one stage per edge; reset flushes every stage to invalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_r[i] <= ROM_TAG_IDLE;
            end
        end else begin
            pipe_r[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign tag_out = pipe_r[LAT-1];

endmodule

// File: rtl/iecdrv_rom_arb.sv
// Shared dual-ROM slot arbiter: one ROM read per drive per ph2 frame, with
// per-drive image select, reset-held drive skipping and overrun detection.
module iecdrv_rom_arb
    import iecdrv_pkg::*;
#(
    parameter int NDR = 4,
    parameter int AW  = 15,
    parameter int DW  = 8,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ph2_f,
    input  logic [NDR-1:0]    drv_en,
    input  logic [NDR*AW-1:0] drv_addr,
    input  logic [NDR-1:0]    drv_rom_sel,
    output logic [AW-1:0]     mem_a,
    output logic              mem_sel,
    input  logic [DW-1:0]     std_q,
    input  logic [DW-1:0]     alt_q,
    output logic [NDR*DW-1:0] drv_data,
    output logic [NDR-1:0]    drv_vld,
    output logic              overrun
);

    localparam int SW = $clog2(NDR + 1);
    localparam logic [SW-1:0] SLOT_IDLE = SW'(NDR);

    logic [SW-1:0]     slot_r;
    logic [SW-1:0]     slot_nxt_s;
    logic              issue_s;
    logic              cur_en_s;
    logic              cur_sel_s;
    logic [AW-1:0]     cur_addr_s;
    logic [AW-1:0]     mem_a_r;
    logic              mem_sel_r;
    logic              overrun_r;
    logic [NDR*DW-1:0] drv_data_r;
    logic [NDR-1:0]    drv_vld_r;
    rom_tag_t          tag_in_s;
    rom_tag_t          tag_out_s;

    assign issue_s = (slot_r < SLOT_IDLE);

    // Pick the request fields of the drive owning the current slot
    always_comb begin
        cur_en_s   = 1'b0;
        cur_sel_s  = 1'b0;
        cur_addr_s = {AW{1'b0}};
        for (int i = 0; i < NDR; i++) begin
            cur_en_s   = (slot_r == SW'(i)) ? drv_en[i]              : cur_en_s;
            cur_sel_s  = (slot_r == SW'(i)) ? drv_rom_sel[i]         : cur_sel_s;
            cur_addr_s = (slot_r == SW'(i)) ? drv_addr[i*AW +: AW]   : cur_addr_s;
        end
    end

    // Next slot: frame start restarts at 0, otherwise advance until idle
    always_comb begin
        slot_nxt_s = slot_r;
        if (ph2_f) begin
            slot_nxt_s = {SW{1'b0}};
        end else if (issue_s) begin
            slot_nxt_s = slot_r + SW'(1);
        end else begin
            slot_nxt_s = slot_r;
        end
    end

    // The slot active on a ph2_f edge still issues before the restart
    assign tag_in_s = rom_tag_make(issue_s & cur_en_s, 3'(slot_r), cur_sel_s);

    // Slot counter, issued address/select and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_r    <= SLOT_IDLE;
            mem_a_r   <= {AW{1'b0}};
            mem_sel_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            slot_r <= slot_nxt_s;
            if (issue_s && cur_en_s) begin
                mem_a_r   <= cur_addr_s;
                mem_sel_r <= cur_sel_s;
            end
            if (ph2_f && issue_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    iecdrv_rom_tagpipe #(
        .LAT (LAT)
    ) u_tagpipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in_s),
        .tag_out (tag_out_s)
    );

    // Steer returning ROM data to the tagged drive and pulse its strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drv_data_r <= {(NDR*DW){1'b0}};
            drv_vld_r  <= {NDR{1'b0}};
        end else begin
            drv_vld_r <= {NDR{1'b0}};
            for (int i = 0; i < NDR; i++) begin
                if (tag_out_s.valid && (tag_out_s.id == 3'(i))) begin
                    drv_data_r[i*DW +: DW] <= tag_out_s.sel ? alt_q : std_q;
                    drv_vld_r[i]           <= 1'b1;
                end
            end
        end
    end

    assign mem_a    = mem_a_r;
    assign mem_sel  = mem_sel_r;
    assign overrun  = overrun_r;
    assign drv_data = drv_data_r;
    assign drv_vld  = drv_vld_r;

endmodule

// File: tb/tb_iecdrv_rom_arb.sv
// Bench for iecdrv_rom_arb: two instances (4 drives/latency 1, 8 drives/latency 3)
// checked every cycle against an event-schedule model of the frame rules.
module tb_iecdrv_rom_arb;

    localparam int AW = 15;

    typedef struct {
        int            unit;
        int            due;
        int            id;
        logic [AW-1:0] a;
        logic          s;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          ph2 [2];
    logic [7:0]    en  [2];
    logic [7:0]    rs  [2];
    logic [AW-1:0] adr [2][8];

    logic [4*AW-1:0] addr_0;
    logic [8*AW-1:0] addr_1;
    logic [AW-1:0]   mem_a_0, mem_a_1;
    logic            mem_sel_0, mem_sel_1;
    logic [7:0]      std_q_0, alt_q_0, std_q_1, alt_q_1;
    logic [31:0]     data_0;
    logic [63:0]     data_1;
    logic [3:0]      vld_0;
    logic [7:0]      vld_1;
    logic            ovr_0, ovr_1;
    logic [AW-1:0]   hist_1 [2];

    int            slot   [2];
    logic [AW-1:0] m_a    [2];
    logic          m_sel  [2];
    logic [7:0]    m_data [2][8];
    logic [7:0]    m_vld  [2];
    logic          m_ovr  [2];
    ev_t           evq [$];
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    function automatic logic [7:0] rom_d(input logic [AW-1:0] a, input logic s);
        return s ? (a[7:0] ^ 8'h5A) : a[7:0];
    endfunction

    function automatic int ndr_of(input int u);
        return (u == 0) ? 4 : 8;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    always_comb begin
        addr_0 = '0;
        addr_1 = '0;
        for (int i = 0; i < 4; i++) addr_0[i*AW +: AW] = adr[0][i];
        for (int i = 0; i < 8; i++) addr_1[i*AW +: AW] = adr[1][i];
    end

    // ROM images: unit 0 answers combinationally, unit 1 after two more edges
    assign std_q_0 = rom_d(mem_a_0, 1'b0);
    assign alt_q_0 = rom_d(mem_a_0, 1'b1);
    always @(posedge clk) begin
        hist_1[0] <= mem_a_1;
        hist_1[1] <= hist_1[0];
    end
    assign std_q_1 = rom_d(hist_1[1], 1'b0);
    assign alt_q_1 = rom_d(hist_1[1], 1'b1);

    iecdrv_rom_arb #(.NDR(4), .AW(AW), .DW(8), .LAT(1)) dut0 (
        .clk(clk), .reset(reset), .ph2_f(ph2[0]), .drv_en(en[0][3:0]),
        .drv_addr(addr_0), .drv_rom_sel(rs[0][3:0]), .mem_a(mem_a_0), .mem_sel(mem_sel_0),
        .std_q(std_q_0), .alt_q(alt_q_0), .drv_data(data_0), .drv_vld(vld_0), .overrun(ovr_0)
    );

    iecdrv_rom_arb #(.NDR(8), .AW(AW), .DW(8), .LAT(3)) dut1 (
        .clk(clk), .reset(reset), .ph2_f(ph2[1]), .drv_en(en[1]),
        .drv_addr(addr_1), .drv_rom_sel(rs[1]), .mem_a(mem_a_1), .mem_sel(mem_sel_1),
        .std_q(std_q_1), .alt_q(alt_q_1), .drv_data(data_1), .drv_vld(vld_1), .overrun(ovr_1)
    );

    task automatic check(input string name, input int u, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d cycle %0d: got %0h, expected %0h", name, u, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            slot[u]  = ndr_of(u);
            m_a[u]   = '0;
            m_sel[u] = 1'b0;
            m_vld[u] = 8'h00;
            m_ovr[u] = 1'b0;
            for (int i = 0; i < 8; i++) m_data[u][i] = 8'h00;
        end
        evq.delete();
    endtask

    // Predict the state after the coming edge from the inputs presented now
    task automatic model_edge();
        int c;
        int old;
        c = cyc + 1;
        cyc = c;
        if (reset) begin
            model_reset();
            return;
        end
        for (int u = 0; u < 2; u++) m_vld[u] = 8'h00;
        for (int k = evq.size() - 1; k >= 0; k--) begin
            if (evq[k].due == c) begin
                m_data[evq[k].unit][evq[k].id] = rom_d(evq[k].a, evq[k].s);
                m_vld[evq[k].unit][evq[k].id]  = 1'b1;
                evq.delete(k);
            end
        end
        for (int u = 0; u < 2; u++) begin
            old = slot[u];
            if (old < ndr_of(u)) begin
                if (en[u][old]) begin
                    m_a[u]   = adr[u][old];
                    m_sel[u] = rs[u][old];
                    evq.push_back('{unit: u, due: c + lat_of(u), id: old,
                                    a: adr[u][old], s: rs[u][old]});
                end
                slot[u] = old + 1;
            end
            if (ph2[u]) begin
                if (old < ndr_of(u)) m_ovr[u] = 1'b1;
                slot[u] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] e0, e1;
        e0 = '0;
        e1 = '0;
        for (int i = 0; i < 4; i++) e0[i*8 +: 8] = m_data[0][i];
        for (int i = 0; i < 8; i++) e1[i*8 +: 8] = m_data[1][i];
        check("mem_a",   0, 64'(mem_a_0),   64'(m_a[0]));
        check("mem_sel", 0, 64'(mem_sel_0), 64'(m_sel[0]));
        check("drv_vld", 0, 64'(vld_0),     64'(m_vld[0][3:0]));
        check("drv_data",0, 64'(data_0),    e0);
        check("overrun", 0, 64'(ovr_0),     64'(m_ovr[0]));
        check("mem_a",   1, 64'(mem_a_1),   64'(m_a[1]));
        check("mem_sel", 1, 64'(mem_sel_1), 64'(m_sel[1]));
        check("drv_vld", 1, 64'(vld_1),     64'(m_vld[1]));
        check("drv_data",1, 64'(data_1),    e1);
        check("overrun", 1, 64'(ovr_1),     64'(m_ovr[1]));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            ph2[u] = 1'b0;
            en[u]  = 8'h00;
            rs[u]  = 8'h00;
            for (int i = 0; i < 8; i++) adr[u][i] = '0;
        end
        model_reset();
        repeat (2) tick();
        check("rst_data", 0, 64'(data_0), 64'h0);
        reset = 1'b0;
        tick();

        // Basic frame: drive i reads 0x1000+i from the standard image
        for (int i = 0; i < 4; i++) adr[0][i] = 15'h1000 + 15'(i);
        en[0] = 8'h0F;
        ph2[0] = 1'b1;
        tick();
        ph2[0] = 1'b0;
        tick();
        check("lit_mem_a", 0, 64'(mem_a_0), 64'h1000);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("lit_vld", 0, 64'(vld_0), 64'(1) << k);
        end
        check("lit_data", 0, 64'(data_0), 64'h03020100);

        // Alternate image on drives 1 and 3
        rs[0] = 8'h0A;
        ph2[0] = 1'b1;
        tick();
        ph2[0] = 1'b0;
        repeat (5) tick();
        check("lit_sel_data", 0, 64'(data_0), 64'h59025B00);

        // Drive 2 held in reset: address holds, its data stays put
        en[0] = 8'h0B;
        for (int i = 0; i < 4; i++) adr[0][i] = 15'h1010 + 15'(i);
        ph2[0] = 1'b1;
        tick();
        ph2[0] = 1'b0;
        repeat (3) tick();
        check("lit_hold_a", 0, 64'(mem_a_0), 64'h1011);
        repeat (2) tick();
        check("lit_skip_data", 0, 64'(data_0), 64'h49024B10);
        check("lit_no_ovr", 0, 64'(ovr_0), 64'h0);

        // Frame restarted two edges in
        en[0] = 8'h0F;
        ph2[0] = 1'b1;
        tick();
        ph2[0] = 1'b0;
        tick();
        ph2[0] = 1'b1;
        tick();
        ph2[0] = 1'b0;
        check("lit_ovr", 0, 64'(ovr_0), 64'h1);
        repeat (6) tick();

        // Eight drives, latency 3: spacing 9 is legal, drive 7 lands at E0+11
        en[1] = 8'hFF;
        for (int i = 0; i < 8; i++) adr[1][i] = 15'($urandom);
        rs[1] = 8'($urandom);
        ph2[1] = 1'b1;
        tick();
        ph2[1] = 1'b0;
        repeat (8) tick();
        ph2[1] = 1'b1;
        tick();
        ph2[1] = 1'b0;
        check("lit_ovr9", 1, 64'(ovr_1), 64'h0);
        tick();
        tick();
        check("lit_vld7", 1, 64'(vld_1), 64'h80);
        repeat (12) tick();

        // Reset mid-frame
        ph2[0] = 1'b1;
        ph2[1] = 1'b1;
        tick();
        ph2[0] = 1'b0;
        ph2[1] = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("lit_rst_ovr", 0, 64'(ovr_0), 64'h0);
        tick();
        reset = 1'b0;
        repeat (10) tick();

        // Randomised frames, enables, addresses, image selects and resets
        for (int n = 0; n < 4000; n++) begin
            for (int u = 0; u < 2; u++) begin
                ph2[u] = ($urandom_range(0, 9) == 0);
                en[u]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
                rs[u]  = 8'($urandom);
                for (int i = 0; i < 8; i++) adr[u][i] = 15'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
